cmp_pipe: RTL

//  Pipelined, parametrised compare unit for the CPU execute path; the successor to the

---
 rtl/cmp_pkg.sv | 28 ++
 rtl/cmp_if.sv | 39 +++
 rtl/cmp_core.sv | 63 ++++++
 rtl/cmp_pipe.sv | 94 +++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared opcode encoding and opcode classification helpers
// for the pipelined compare unit.
package cmp_pkg;

  typedef enum logic [3:0] {
    OP_EQ   = 4'd0,
    OP_NE   = 4'd1,
    OP_LT   = 4'd2,
    OP_GE   = 4'd3,
    OP_LTU  = 4'd4,
    OP_GEU  = 4'd5,
    OP_MIN  = 4'd6,
    OP_MAX  = 4'd7,
    OP_MINU = 4'd8,
    OP_MAXU = 4'd9
  } cmp_op_e;

  localparam logic [3:0] OP_LAST = 4'd9;

  function automatic logic is_signed_op(cmp_op_e op);
    return op inside {OP_EQ, OP_NE, OP_LT, OP_GE, OP_MIN, OP_MAX};
  endfunction

  function automatic logic is_branch_op(cmp_op_e op);
    return op inside {OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU};
  endfunction

endpackage

// File: rtl/cmp_if.sv
// Valid/ready request and result bundle of the compare unit.
// master = issuing/consuming side, slave = cmp_pipe.
interface cmp_if #(
  parameter int N     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [N-1:0]     in_rs1;
  logic [N-1:0]     in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             out_eq;
  logic             out_gt;
  logic             out_lt;
  logic             out_taken;
  logic [N-1:0]     out_result;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag,
    output flush, out_ready,
    input  in_ready, out_valid, out_tag,
    input  out_eq, out_gt, out_lt, out_taken,
    input  out_result, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag,
    input  flush, out_ready,
    output in_ready, out_valid, out_tag,
    output out_eq, out_gt, out_lt, out_taken,
    output out_result, out_illegal
  );
endinterface

// File: rtl/cmp_core.sv
// Combinational compare datapath: flags, branch
// condition and min/max selection for one operation.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         eq,
  output logic         gt,
  output logic         lt,
  output logic         taken,
  output logic [N-1:0] result,
  output logic         illegal
);

  cmp_op_e opc;
  logic    sgn;
  logic    br;
  logic    is_min;
  logic    raw_eq;
  logic    raw_lt;

  assign opc     = cmp_op_e'(op);
  assign illegal = op > OP_LAST;
  assign sgn     = is_signed_op(opc);
  assign br      = is_branch_op(opc);
  assign is_min  = opc inside {OP_MIN, OP_MINU};
  assign raw_eq  = a == b;
  assign raw_lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    eq    = 1'b0;
    gt    = 1'b0;
    lt    = 1'b0;
    taken = 1'b0;
    if (!illegal) begin
      eq = raw_eq;
      lt = raw_lt;
      gt = !raw_eq && !raw_lt;
    end
    unique case (opc)
      OP_EQ:          taken = raw_eq;
      OP_NE:          taken = !raw_eq;
      OP_LT, OP_LTU:  taken = raw_lt;
      OP_GE, OP_GEU:  taken = !raw_lt;
      default:        taken = 1'b0;
    endcase
  end

  // min picks a when a<b, max picks a when !(a<b)
  always_comb begin
    result = '0;
    unique case (1'b1)
      illegal: result = '0;
      br:      result = {{(N-1){1'b0}}, taken};
      default: result = (raw_lt == is_min) ? a : b;
    endcase
  end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage compare pipeline: S1 holds the operation,
// S2 holds the computed result, valid/ready between them.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int N     = 16,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  cmp_if.slave bus
);

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [N-1:0]     s1_a;
  logic [N-1:0]     s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_ready;
  logic             accept;
  logic             advance;

  logic             c_eq;
  logic             c_gt;
  logic             c_lt;
  logic             c_taken;
  logic             c_illegal;
  logic [N-1:0]     c_result;

  assign s2_ready     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (!s1_valid || s2_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = s1_valid && s2_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      if (bus.flush)   s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (advance) s1_valid <= 1'b0;
      if (accept) begin
        s1_op  <= bus.in_op;
        s1_a   <= bus.in_rs1;
        s1_b   <= bus.in_rs2;
        s1_tag <= bus.in_tag;
      end
    end
  end

  cmp_core #(.N(N)) u_core (
    .a       (s1_a),
    .b       (s1_b),
    .op      (s1_op),
    .eq      (c_eq),
    .gt      (c_gt),
    .lt      (c_lt),
    .taken   (c_taken),
    .result  (c_result),
    .illegal (c_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_tag     <= '0;
      bus.out_eq      <= 1'b0;
      bus.out_gt      <= 1'b0;
      bus.out_lt      <= 1'b0;
      bus.out_taken   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      if (bus.flush)         bus.out_valid <= 1'b0;
      else if (advance)      bus.out_valid <= 1'b1;
      else if (bus.out_ready) bus.out_valid <= 1'b0;
      if (advance) begin
        bus.out_tag     <= s1_tag;
        bus.out_eq      <= c_eq;
        bus.out_gt      <= c_gt;
        bus.out_lt      <= c_lt;
        bus.out_taken   <= c_taken;
        bus.out_result  <= c_result;
        bus.out_illegal <= c_illegal;
      end
    end
  end

endmodule
